// File: rtl/dual_issue_queue_if.sv
// Fetch-side and decode-side signals of the dual-issue instruction queue.
interface dual_issue_queue_if #(
  parameter int DEPTH = 8,
  parameter int XLEN  = 32
);
  logic [63:0]             InstrF;
  logic [1:0]              ValidF;
  logic [XLEN-1:0]         PCF;
  logic                    ReadyF;
  logic                    StallD;
  logic                    FlushD;
  logic [31:0]             InstrD1;
  logic [31:0]             InstrD2;
  logic [XLEN-1:0]         PCD1;
  logic [XLEN-1:0]         PCD2;
  logic                    ValidD1;
  logic                    ValidD2;
  logic [$clog2(DEPTH):0]  Count;

  modport master (
    output InstrF, ValidF, PCF, StallD, FlushD,
    input  ReadyF, InstrD1, InstrD2, PCD1, PCD2, ValidD1, ValidD2, Count
  );

  modport slave (
    input  InstrF, ValidF, PCF, StallD, FlushD,
    output ReadyF, InstrD1, InstrD2, PCD1, PCD2, ValidD1, ValidD2, Count
  );
endinterface

// File: rtl/dual_issue_queue.sv
// Fetch-to-decode instruction queue that pairs head/head+1 into two registered decode lanes.
// One edge of latency from enqueue to decode; ReadyF drops when fewer than two entries are free.
module dual_issue_queue #(
  parameter int          DEPTH = 8,
  parameter int          XLEN  = 32,
  parameter logic [31:0] NOP   = 32'h00000013
) (
  input logic               clk,
  input logic               rst_n,
  dual_issue_queue_if.slave q
);
  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  logic [31:0]     instr_mem_q [DEPTH];
  logic [31:0]     instr_mem_d [DEPTH];
  logic [XLEN-1:0] pc_mem_q    [DEPTH];
  logic [XLEN-1:0] pc_mem_d    [DEPTH];

  logic [PW-1:0]   head_q, head_d, tail_q, tail_d, count;
  logic [31:0]     instr_d1_q, instr_d1_d, instr_d2_q, instr_d2_d;
  logic [XLEN-1:0] pc_d1_q, pc_d1_d, pc_d2_q, pc_d2_d;
  logic            valid_d1_q, valid_d1_d, valid_d2_q, valid_d2_d;

  logic            ready, enq_en, pair_ok;
  logic [1:0]      enq_n, deq;
  logic [AW-1:0]   h_idx, s_idx, w0_idx, w1_idx;
  logic [31:0]     h_ins, s_ins;
  logic            h_wr, s_wr;

  function automatic logic is_load(input logic [31:0] i);
    return i[6:0] == 7'b0000011;
  endfunction

  function automatic logic is_store(input logic [31:0] i);
    return i[6:0] == 7'b0100011;
  endfunction

  function automatic logic is_ctrl(input logic [31:0] i);
    return (i[6:0] == 7'b1100011) || (i[6:0] == 7'b1101111) || (i[6:0] == 7'b1100111);
  endfunction

  function automatic logic writes_rd(input logic [31:0] i);
    return !is_store(i) && (i[6:0] != 7'b1100011) && (i[11:7] != 5'd0);
  endfunction

  // Pointers carry a wrap bit, so the plain difference is the exact occupancy even when full.
  assign count  = tail_q - head_q;
  assign ready  = count <= PW'(DEPTH - 2);
  assign enq_en = ready && (|q.ValidF) && !q.FlushD;
  assign enq_n  = {1'b0, q.ValidF[0]} + {1'b0, q.ValidF[1]};

  assign h_idx  = head_q[AW-1:0];
  assign s_idx  = h_idx + AW'(1);
  assign w0_idx = tail_q[AW-1:0];
  assign w1_idx = w0_idx + AW'(1);
  assign h_ins  = instr_mem_q[h_idx];
  assign s_ins  = instr_mem_q[s_idx];
  assign h_wr   = writes_rd(h_ins);
  assign s_wr   = writes_rd(s_ins);

  // RAW compares against rs2 unconditionally; a false split only costs a cycle.
  assign pair_ok = (count >= PW'(2)) && !is_ctrl(h_ins)
                && !is_store(s_ins) && !is_ctrl(s_ins)
                && !(h_wr && ((h_ins[11:7] == s_ins[19:15]) || (h_ins[11:7] == s_ins[24:20])))
                && !(h_wr && s_wr && (h_ins[11:7] == s_ins[11:7]))
                && !(is_store(h_ins) && is_load(s_ins));

  always_comb begin
    instr_mem_d = instr_mem_q;
    pc_mem_d    = pc_mem_q;
    head_d      = head_q;
    tail_d      = tail_q;
    instr_d1_d  = instr_d1_q;
    instr_d2_d  = instr_d2_q;
    pc_d1_d     = pc_d1_q;
    pc_d2_d     = pc_d2_q;
    valid_d1_d  = valid_d1_q;
    valid_d2_d  = valid_d2_q;
    deq         = 2'd0;

    if (q.FlushD) begin
      head_d     = tail_q;
      valid_d1_d = 1'b0;
      valid_d2_d = 1'b0;
      instr_d1_d = NOP;
      instr_d2_d = NOP;
      pc_d1_d    = '0;
      pc_d2_d    = '0;
    end else begin
      if (enq_en) begin
        if (q.ValidF[0]) begin
          instr_mem_d[w0_idx] = q.InstrF[31:0];
          pc_mem_d[w0_idx]    = q.PCF;
        end
        if (q.ValidF[1]) begin
          instr_mem_d[q.ValidF[0] ? w1_idx : w0_idx] = q.InstrF[63:32];
          pc_mem_d[q.ValidF[0] ? w1_idx : w0_idx]    = q.PCF + XLEN'(4);
        end
        tail_d = tail_q + PW'(enq_n);
      end
      if (!q.StallD) begin
        valid_d1_d = 1'b0;
        valid_d2_d = 1'b0;
        instr_d1_d = NOP;
        instr_d2_d = NOP;
        pc_d1_d    = '0;
        pc_d2_d    = '0;
        if (count != '0) begin
          if (is_load(h_ins)) begin
            valid_d2_d = 1'b1;
            instr_d2_d = h_ins;
            pc_d2_d    = pc_mem_q[h_idx];
            deq        = 2'd1;
          end else begin
            valid_d1_d = 1'b1;
            instr_d1_d = h_ins;
            pc_d1_d    = pc_mem_q[h_idx];
            deq        = 2'd1;
            if (pair_ok) begin
              valid_d2_d = 1'b1;
              instr_d2_d = s_ins;
              pc_d2_d    = pc_mem_q[s_idx];
              deq        = 2'd2;
            end
          end
        end
        head_d = head_q + PW'(deq);
      end
    end
  end

  always_ff @(posedge clk) begin
    instr_mem_q <= instr_mem_d;
    pc_mem_q    <= pc_mem_d;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      head_q     <= '0;
      tail_q     <= '0;
      instr_d1_q <= NOP;
      instr_d2_q <= NOP;
      pc_d1_q    <= '0;
      pc_d2_q    <= '0;
      valid_d1_q <= 1'b0;
      valid_d2_q <= 1'b0;
    end else begin
      head_q     <= head_d;
      tail_q     <= tail_d;
      instr_d1_q <= instr_d1_d;
      instr_d2_q <= instr_d2_d;
      pc_d1_q    <= pc_d1_d;
      pc_d2_q    <= pc_d2_d;
      valid_d1_q <= valid_d1_d;
      valid_d2_q <= valid_d2_d;
    end
  end

  assign q.ReadyF  = ready;
  assign q.Count   = count;
  assign q.InstrD1 = instr_d1_q;
  assign q.InstrD2 = instr_d2_q;
  assign q.PCD1    = pc_d1_q;
  assign q.PCD2    = pc_d2_q;
  assign q.ValidD1 = valid_d1_q;
  assign q.ValidD2 = valid_d2_q;
endmodule

// File: tb/tb_dual_issue_queue.sv
// Directed bench for dual_issue_queue: queue-based reference model checked every cycle plus literal anchors.
module tb_dual_issue_queue;
  localparam int DEPTH = 8;
  localparam int XLEN  = 32;
  localparam logic [31:0] NOP = 32'h00000013;

  localparam logic [31:0] ADDI1 = 32'h00100093; // addi x1,x0,1
  localparam logic [31:0] ADDI2 = 32'h00200113; // addi x2,x0,2
  localparam logic [31:0] ADDI5 = 32'h00300293; // addi x5,x0,3
  localparam logic [31:0] ADD6  = 32'h00528333; // add x6,x5,x5
  localparam logic [31:0] LW7   = 32'h00002383; // lw x7,0(x0)
  localparam logic [31:0] LW8   = 32'h00002403; // lw x8,0(x0)
  localparam logic [31:0] BEQ   = 32'h00000463; // beq x0,x0,8
  localparam logic [31:0] SW    = 32'h00112023; // sw x1,0(x2)

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  dual_issue_queue_if #(.DEPTH(DEPTH), .XLEN(XLEN)) q ();

  dual_issue_queue #(.DEPTH(DEPTH), .XLEN(XLEN), .NOP(NOP)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .q     (q)
  );

  typedef struct packed {
    logic [31:0] ins;
    logic [31:0] pc;
  } ent_t;

  ent_t        mq[$];
  logic [31:0] m_i1, m_i2, m_p1, m_p2;
  logic        m_v1, m_v2;
  int          checks = 0;
  int          errors = 0;

  function automatic bit m_load(input logic [31:0] i);
    return i[6:0] == 7'b0000011;
  endfunction
  function automatic bit m_store(input logic [31:0] i);
    return i[6:0] == 7'b0100011;
  endfunction
  function automatic bit m_ctrl(input logic [31:0] i);
    return i[6:0] inside {7'b1100011, 7'b1101111, 7'b1100111};
  endfunction
  function automatic bit m_wr(input logic [31:0] i);
    return !m_store(i) && i[6:0] != 7'b1100011 && i[11:7] != 5'd0;
  endfunction
  function automatic bit m_pair(input logic [31:0] h, input logic [31:0] s);
    if (m_ctrl(h) || m_store(s) || m_ctrl(s)) return 0;
    if (m_wr(h) && (h[11:7] == s[19:15] || h[11:7] == s[24:20])) return 0;
    if (m_wr(h) && m_wr(s) && h[11:7] == s[11:7]) return 0;
    if (m_store(h) && m_load(s)) return 0;
    return 1;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic bubble();
    m_v1 = 0; m_v2 = 0; m_i1 = NOP; m_i2 = NOP; m_p1 = '0; m_p2 = '0;
  endtask

  // Advance the model and the DUT by one edge, then compare every output.
  task automatic step();
    int   n;
    ent_t e;
    n = mq.size();
    if (!rst_n) begin
      mq.delete();
      bubble();
    end else if (q.FlushD) begin
      mq.delete();
      bubble();
    end else begin
      if (!q.StallD) begin
        bubble();
        if (n >= 1) begin
          if (m_load(mq[0].ins)) begin
            m_v2 = 1; m_i2 = mq[0].ins; m_p2 = mq[0].pc;
            void'(mq.pop_front());
          end else begin
            m_v1 = 1; m_i1 = mq[0].ins; m_p1 = mq[0].pc;
            if (n >= 2 && m_pair(mq[0].ins, mq[1].ins)) begin
              m_v2 = 1; m_i2 = mq[1].ins; m_p2 = mq[1].pc;
              void'(mq.pop_front());
            end
            void'(mq.pop_front());
          end
        end
      end
      if (n <= DEPTH - 2) begin
        if (q.ValidF[0]) begin
          e.ins = q.InstrF[31:0]; e.pc = q.PCF; mq.push_back(e);
        end
        if (q.ValidF[1]) begin
          e.ins = q.InstrF[63:32]; e.pc = q.PCF + 32'd4; mq.push_back(e);
        end
      end
    end
    @(posedge clk);
    #1;
    chk("ValidD1", q.ValidD1, m_v1);
    chk("ValidD2", q.ValidD2, m_v2);
    chk("InstrD1", q.InstrD1, m_i1);
    chk("InstrD2", q.InstrD2, m_i2);
    chk("PCD1", q.PCD1, m_p1);
    chk("PCD2", q.PCD2, m_p2);
    chk("Count", q.Count, mq.size());
    chk("ReadyF", q.ReadyF, mq.size() <= DEPTH - 2);
  endtask

  task automatic fetch(input logic [31:0] i0, input logic [31:0] i1, input logic [1:0] v,
                       input logic [31:0] pc);
    q.InstrF = {i1, i0}; q.ValidF = v; q.PCF = pc;
    step();
    q.ValidF = 2'b00;
  endtask

  initial begin
    q.InstrF = '0; q.ValidF = 2'b00; q.PCF = '0; q.StallD = 1'b0; q.FlushD = 1'b0;
    bubble();
    step();
    step();
    chk("rst InstrD1", q.InstrD1, 32'h00000013);
    chk("rst Count", q.Count, 0);
    chk("rst ReadyF", q.ReadyF, 1);
    rst_n = 1'b1;

    // Independent pair
    fetch(ADDI1, ADDI2, 2'b11, 32'h100);
    chk("pair V1 after enq", q.ValidD1, 0);
    step();
    chk("pair InstrD1", q.InstrD1, 32'h00100093);
    chk("pair PCD1", q.PCD1, 32'h100);
    chk("pair InstrD2", q.InstrD2, 32'h00200113);
    chk("pair PCD2", q.PCD2, 32'h104);
    chk("pair V2", q.ValidD2, 1);
    chk("pair Count", q.Count, 0);

    // RAW split
    fetch(ADDI5, ADD6, 2'b11, 32'h140);
    step();
    chk("raw c1 InstrD1", q.InstrD1, 32'h00300293);
    chk("raw c1 V2", q.ValidD2, 0);
    step();
    chk("raw c2 InstrD1", q.InstrD1, 32'h00528333);
    chk("raw c2 PCD1", q.PCD1, 32'h144);

    // Load steering then lone branch
    fetch(LW7, BEQ, 2'b11, 32'h180);
    step();
    chk("lw V1", q.ValidD1, 0);
    chk("lw InstrD2", q.InstrD2, 32'h00002383);
    step();
    chk("beq InstrD1", q.InstrD1, 32'h00000463);
    chk("beq V2", q.ValidD2, 0);

    // Fill under stall across the pointer wrap; lone slot-1 fetch takes PCF+4
    q.StallD = 1'b1;
    fetch(32'h0, ADDI1, 2'b10, 32'h200);
    fetch(LW7, ADDI2, 2'b11, 32'h210);
    fetch(SW, LW8, 2'b11, 32'h220);
    fetch(ADDI5, ADD6, 2'b11, 32'h230);
    chk("fill Count7", q.Count, 7);
    chk("fill ReadyF", q.ReadyF, 0);
    fetch(ADDI1, ADDI2, 2'b11, 32'h240);
    chk("extra ignored", q.Count, 7);
    q.StallD = 1'b0;
    step();
    chk("drain PCD1", q.PCD1, 32'h204);
    chk("drain InstrD2", q.InstrD2, 32'h00002383);
    chk("drain Count", q.Count, 5);
    for (int k = 0; k < 8; k++) step();
    chk("drained", q.Count, 0);

    // Flush at Count=5 with a simultaneous fetch
    q.StallD = 1'b1;
    fetch(ADDI1, 32'h0, 2'b01, 32'h300);
    fetch(ADDI2, ADDI5, 2'b11, 32'h310);
    fetch(ADD6, LW7, 2'b11, 32'h320);
    chk("pre-flush Count", q.Count, 5);
    q.FlushD = 1'b1;
    fetch(ADDI1, ADDI2, 2'b11, 32'h330);
    q.FlushD = 1'b0;
    chk("flush Count", q.Count, 0);
    chk("flush V1", q.ValidD1, 0);
    chk("flush V2", q.ValidD2, 0);
    chk("flush InstrD1", q.InstrD1, 32'h00000013);
    chk("flush InstrD2", q.InstrD2, 32'h00000013);
    q.StallD = 1'b0;
    step();

    // Reset with a full queue, then normal issue
    q.StallD = 1'b1;
    for (int k = 0; k < 4; k++) fetch(ADDI1, ADDI2, 2'b11, 32'h400 + 32'(k * 8));
    chk("full Count", q.Count, 8);
    rst_n = 1'b0;
    fetch(ADDI5, ADD6, 2'b11, 32'h500);
    rst_n = 1'b1;
    q.StallD = 1'b0;
    chk("reset Count", q.Count, 0);
    chk("reset InstrD2", q.InstrD2, 32'h00000013);
    chk("reset ReadyF", q.ReadyF, 1);
    fetch(ADDI1, ADDI2, 2'b11, 32'h600);
    step();
    chk("post-rst InstrD1", q.InstrD1, 32'h00100093);
    chk("post-rst PCD2", q.PCD2, 32'h604);
    chk("post-rst V2", q.ValidD2, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
